// File: rtl/flag_branch_ctrl_if.sv
// EX-stage flag / branch / halt bundle between the pipeline and flag_branch_ctrl.
// The master is the pipeline side; the slave is the flag/branch controller.
interface flag_branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [2:0]       alu_flag;
  logic             stall;
  logic             flush;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic             br_taken;
  logic [2:0]       flags_q;
  logic             halt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output ex_valid, ex_opcode, alu_flag, stall, flush, br_valid, br_cond,
    input  br_taken, flags_q, halt, taken_cnt
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_flag, stall, flush, br_valid, br_cond,
    output br_taken, flags_q, halt, taken_cnt
  );
endinterface

// File: rtl/flag_branch_ctrl.sv
// Z/V/N flag register with same-cycle EX bypass into branch resolution, plus HLT drain/halt sequencing.
// br_taken is combinational; flags, halt and taken_cnt update on the edge; stall holds EX, flush squashes it.
module flag_branch_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  flag_branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t           state, state_d;
  logic [2:0]       drain_cnt, drain_cnt_d;
  logic [2:0]       flags_q, eff_flags;
  logic             halt_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic             commit;
  logic             cond_ok;
  logic             br_taken;

  function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cc)
      3'b000:  cond_true = ~z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = ~z & ~n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z | (~z & ~n);
      3'b101:  cond_true = n | z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  assign commit = bus.ex_valid & ~bus.stall & ~bus.flush & (state == RUN);

  // eff_flags is both the next flag register value and the branch bypass source.
  always_comb begin
    eff_flags = flags_q;
    if (commit) begin
      case (bus.ex_opcode)
        OP_ADD, OP_SUB:                 eff_flags = bus.alu_flag;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: eff_flags = {bus.alu_flag[2], flags_q[1:0]};
        default:                        eff_flags = flags_q;
      endcase
    end
  end

  assign cond_ok  = cond_true(bus.br_cond, eff_flags);
  assign br_taken = bus.br_valid & (state == RUN) & cond_ok;

  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    case (state)
      RUN: begin
        if (commit && bus.ex_opcode == OP_HLT) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == 3'd0) begin
          state_d = HALTED;
        end else begin
          drain_cnt_d = drain_cnt - 3'd1;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      drain_cnt   <= 3'd0;
      flags_q     <= 3'b000;
      halt_q      <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      flags_q   <= eff_flags;
      halt_q    <= (state_d == HALTED);
      if (br_taken && !bus.stall) begin
        taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.br_taken  = br_taken;
  assign bus.flags_q   = flags_q;
  assign bus.halt      = halt_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl: flag writes, bypass, condition sweep, halt drain, counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_flag_branch_ctrl;

  localparam int CNT_W = 4;
  localparam int DRAIN = 2;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] XOR = 4'b0010;
  localparam logic [3:0] SLL = 4'b0100;
  localparam logic [3:0] SRA = 4'b0101;
  localparam logic [3:0] ROR = 4'b0110;
  localparam logic [3:0] LW  = 4'b1000;
  localparam logic [3:0] BOP = 4'b1100;
  localparam logic [3:0] HLT = 4'b1111;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  flag_branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  flag_branch_ctrl #(
    .DRAIN_CYCLES(DRAIN),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ex_valid  = 1'b0;
    bus.ex_opcode = 4'd0;
    bus.alu_flag  = 3'd0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_cond   = 3'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic commit(input logic [3:0] op, input logic [2:0] fl);
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = op;
    bus.alu_flag  = fl;
    tick();
    bus.ex_valid  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.br_valid = 1'b1;
    bus.br_cond  = 3'b111;
    #3;
    total++; if (bus.flags_q !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", bus.flags_q); end
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b expected 0", bus.halt); end
    total++; if (bus.taken_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", bus.taken_cnt); end
    total++; if (bus.br_taken !== 1'b1) begin bad++; $display("FAIL reset_uncond: got %b expected 1", bus.br_taken); end
    bus.br_cond = 3'b001;
    #1;
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL reset_eq: got %b expected 0", bus.br_taken); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_flag_write();
    logic [3:0] ops [9];
    logic [2:0] fls [9];
    logic [2:0] exp [9];
    ops = '{ADD,    XOR,    SLL,    SRA,    ROR,    LW,     BOP,    SUB,    4'b0111};
    fls = '{3'b101, 3'b010, 3'b100, 3'b000, 3'b100, 3'b010, 3'b010, 3'b010, 3'b101};
    exp = '{3'b101, 3'b001, 3'b101, 3'b001, 3'b101, 3'b101, 3'b101, 3'b010, 3'b010};
    for (int i = 0; i < 9; i++) begin
      commit(ops[i], fls[i]);
      total++;
      if (bus.flags_q !== exp[i]) begin
        bad++;
        $display("FAIL flag_write[%0d] op=%b: got %b expected %b", i, ops[i], bus.flags_q, exp[i]);
      end
    end
  endtask

  task automatic test_bypass();
    commit(SUB, 3'b000);
    total++; if (bus.flags_q !== 3'b000) begin bad++; $display("FAIL bypass_setup: got %b expected 000", bus.flags_q); end
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = SUB;
    bus.alu_flag  = 3'b100;
    bus.br_valid  = 1'b1;
    bus.br_cond   = 3'b001;
    #1;
    total++; if (bus.br_taken !== 1'b1) begin bad++; $display("FAIL bypass_eq: got %b expected 1", bus.br_taken); end
    bus.br_cond = 3'b000;
    #1;
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL bypass_ne: got %b expected 0", bus.br_taken); end
    bus.br_cond = 3'b001;
    bus.stall   = 1'b1;
    #1;
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL bypass_stall: got %b expected 0", bus.br_taken); end
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    #1;
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL bypass_flush: got %b expected 0", bus.br_taken); end
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    tick();
    total++; if (bus.flags_q !== 3'b000) begin bad++; $display("FAIL stall_no_write: got %b expected 000", bus.flags_q); end
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    total++; if (bus.flags_q !== 3'b000) begin bad++; $display("FAIL flush_no_write: got %b expected 000", bus.flags_q); end
    clear_inputs();
  endtask

  task automatic test_cond_sweep();
    logic [7:0] mask [8];
    // mask[cond][flags] where flags = {Z,V,N}
    mask = '{8'h0F, 8'hF0, 8'h05, 8'hAA, 8'hF5, 8'hFA, 8'hCC, 8'hFF};
    for (int f = 0; f < 8; f++) begin
      commit(ADD, 3'(f));
      bus.br_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
        bus.br_cond = 3'(c);
        #1;
        total++;
        if (bus.br_taken !== mask[c][f]) begin
          bad++;
          $display("FAIL cond_sweep c=%0d f=%b: got %b expected %b", c, 3'(f), bus.br_taken, mask[c][f]);
        end
        tick();
      end
      bus.br_valid = 1'b0;
    end
    bus.br_cond = 3'b111;
    #1;
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL br_valid_low: got %b expected 0", bus.br_taken); end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    commit(ADD, 3'b101);
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = HLT;
    tick();
    bus.ex_opcode = ADD;
    bus.alu_flag  = 3'b010;
    bus.br_valid  = 1'b1;
    bus.br_cond   = 3'b111;
    #1;
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL drain_br_block: got %b expected 0", bus.br_taken); end
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL halt_t0: got %b expected 0", bus.halt); end
    tick();
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL halt_t1: got %b expected 0", bus.halt); end
    total++; if (bus.flags_q !== 3'b101) begin bad++; $display("FAIL drain_no_write: got %b expected 101", bus.flags_q); end
    tick();
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL halt_t2: got %b expected 1", bus.halt); end
    total++; if (bus.flags_q !== 3'b101) begin bad++; $display("FAIL halted_flags: got %b expected 101", bus.flags_q); end
    tick();
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL halt_sticky: got %b expected 1", bus.halt); end
    total++; if (bus.br_taken !== 1'b0) begin bad++; $display("FAIL halted_br: got %b expected 0", bus.br_taken); end
    total++; if (bus.taken_cnt !== 4'd0) begin bad++; $display("FAIL halted_cnt: got %0d expected 0", bus.taken_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL async_reset_halt: got %b expected 0", bus.halt); end
    total++; if (bus.flags_q !== 3'b000) begin bad++; $display("FAIL async_reset_flags: got %b expected 000", bus.flags_q); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hlt_ignored();
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = HLT;
    bus.flush     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL hlt_flush[%0d]: got %b expected 0", i, bus.halt); end
    end
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL hlt_stall[%0d]: got %b expected 0", i, bus.halt); end
    end
    bus.stall = 1'b0;
    commit(ADD, 3'b110);
    total++; if (bus.flags_q !== 3'b110) begin bad++; $display("FAIL still_run: got %b expected 110", bus.flags_q); end
    clear_inputs();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    bus.br_valid = 1'b1;
    bus.br_cond  = 3'b111;
    repeat (15) tick();
    total++; if (bus.taken_cnt !== 4'd15) begin bad++; $display("FAIL cnt_15: got %0d expected 15", bus.taken_cnt); end
    repeat (2) tick();
    total++; if (bus.taken_cnt !== 4'd1) begin bad++; $display("FAIL cnt_wrap: got %0d expected 1", bus.taken_cnt); end
    bus.stall = 1'b1;
    tick();
    total++; if (bus.taken_cnt !== 4'd1) begin bad++; $display("FAIL cnt_stall: got %0d expected 1", bus.taken_cnt); end
    bus.stall   = 1'b0;
    bus.br_cond = 3'b110;
    tick();
    total++; if (bus.taken_cnt !== 4'd1) begin bad++; $display("FAIL cnt_not_taken: got %0d expected 1", bus.taken_cnt); end
    bus.br_cond = 3'b000;
    tick();
    total++; if (bus.taken_cnt !== 4'd2) begin bad++; $display("FAIL cnt_ne_taken: got %0d expected 2", bus.taken_cnt); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_flag_write();
    test_bypass();
    test_cond_sweep();
    test_halt();
    test_hlt_ignored();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_branch_ctrl.md
Name: flag_branch_ctrl

Overview:
- Consumes the 3-bit flag vector from the 16-bit ALU at the EX stage and holds the architectural Z/V/N flag register.
- Resolves B/BR condition codes against those flags, with same-cycle bypass from EX.
- Sequences processor halt after HLT retires through EX.
- Sits beside the ALU; feeds PC-select logic and top-level halt.

Parameters:
- DRAIN_CYCLES, 2, cycles between HLT leaving EX and halt assertion (lets MEM/WB retire); legal 1..7.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_opcode  input  4  opcode of EX instruction (0000 ADD … 1111 HLT)
- alu_flag  input  3  ALU flags {Z,V,N}: [2]=Z, [1]=V, [0]=N
- stall  input  1  pipeline stall; EX instruction does not advance this cycle
- flush  input  1  squash EX instruction this cycle
- br_valid  input  1  decode stage holds B (1100) or BR (1101)
- br_cond  input  3  condition code ccc
- br_taken  output  1  branch condition true (combinational)
- flags_q  output  3  registered {Z,V,N}
- halt  output  1  processor halted (registered, sticky)
- taken_cnt  output  CNT_W  count of taken branches

Behaviour:
- Reset (async, rst_n=0): flags_q=3'b000, halt=0, FSM=RUN, drain counter=0, taken_cnt=0. br_taken then follows its combinational equation.
- commit = ex_valid & ~stall & ~flush & (FSM==RUN).
- Flag write on rising edge when commit:
  - ADD (0000), SUB (0001): write Z, V, N.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): write Z only; V and N hold.
  - All other opcodes, including RED, PADDSB, LW, SW, LLB and LHB: no flag change.
- eff_flags is the value flags_q will take at the next edge if commit; otherwise eff_flags = flags_q. This is the same-cycle bypass, so a flag-setting instruction in EX directly ahead of a branch is honoured with zero added latency.
- br_taken = br_valid & (FSM==RUN) & cond(br_cond, eff_flags):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OV: V=1
  - 111 UNCOND: 1
- taken_cnt increments by 1 on each edge where br_taken & ~stall. It wraps from all-ones to 0 with no saturation.
- Halt FSM:
  - RUN: commit & ex_opcode==1111 → DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - DRAIN: counter decrements each cycle regardless of stall. At 0 → HALTED. Flag writes and br_taken are blocked (younger instructions are squashed).
  - HALTED: halt=1. Remains until reset. No flag writes; br_taken=0; taken_cnt frozen.
  - halt asserts exactly DRAIN_CYCLES cycles after the HLT commit edge.
- Simultaneous events:
  - stall with a flag-setting EX: no write, no bypass.
  - flush overrides stall.
  - HLT under flush or stall: ignored, FSM stays RUN.
- rst_n asserted mid-DRAIN or in HALTED: immediate return to RUN with all outputs reset.
- Opcode values 1100–1110 in EX: no effect.

Test Plan:
- Reset then ADD commit with alu_flag=3'b101 → next cycle flags_q=3'b101. A following XOR commit with alu_flag=3'b010 → flags_q=3'b001 (Z cleared, V/N held).
- flags_q=3'b000; SUB in EX with alu_flag=3'b100 while br_valid, br_cond=001 in the same cycle → br_taken=1 (bypass). Repeat with stall=1 → br_taken=0.
- Sweep all 8 ccc against all 8 flag values with ex_valid=0 → br_taken matches the truth table (64 checks). cond 111 → always 1.
- HLT commit at cycle T, DRAIN_CYCLES=2 → halt=0 at T+1, halt=1 at T+2 and after. An ADD committed at T+1 → flags_q unchanged.
- HLT with flush=1 → FSM stays RUN, halt=0. Assert rst_n=0 while halt=1 → halt=0 asynchronously, before the next clk edge.
- CNT_W=4: 17 taken unconditional branches → taken_cnt=1 (wrap). A taken branch with stall=1 → no increment.
